// File: rtl/pipelined_mant_mult.sv
// Exact unsigned mantissa multiplier with tag, flush and valid/ready flow control. Latency is STAGES cycles.
// Operand register, then 3:2 carry-save layers, then a CPA into the output register. Stalls hold data, and bubbles collapse.
module pipelined_mant_mult #(
    parameter int MANT_W = 10,
    parameter int HIDDEN = 1,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MANT_W-1:0]            a,
    input  logic [MANT_W-1:0]            b,
    input  logic [TAG_W-1:0]             tag_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*(MANT_W+HIDDEN)-1:0] p,
    output logic                         norm,
    output logic [TAG_W-1:0]             tag_out,
    output logic                         busy
);
    localparam int OP_W = MANT_W + HIDDEN;
    localparam int P_W  = 2 * OP_W;

    typedef logic [OP_W-1:0][P_W-1:0] rows_t;

    function automatic int cs_levels(input int rows);
        int r = rows;
        int n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            n++;
        end
        return n;
    endfunction

    localparam int LVL     = cs_levels(OP_W);
    localparam int NMID    = (STAGES > 2) ? STAGES - 2 : 1;
    localparam int FIN_LVL = (STAGES > 2) ? 0 : LVL;

    function automatic rows_t pp_gen(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
        rows_t r;
        for (int i = 0; i < OP_W; i++) r[i] = y[i] ? (P_W'(x) << i) : '0;
        return r;
    endfunction

    // Live rows always form a prefix, so each layer leaves 2*(r/3)+r%3 rows.
    function automatic rows_t csa_level(input rows_t r);
        rows_t o = '0;
        for (int i = 0; i < OP_W / 3; i++) begin
            o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
            o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
        end
        for (int j = 0; j < OP_W % 3; j++) o[2*(OP_W/3)+j] = r[3*(OP_W/3)+j];
        return o;
    endfunction

    function automatic rows_t csa_reduce(input rows_t r, input int n);
        rows_t o = r;
        for (int i = 0; i < n; i++) o = csa_level(o);
        return o;
    endfunction

    function automatic logic [P_W-1:0] cpa(input rows_t r);
        logic [P_W-1:0] s = '0;
        for (int i = 0; i < OP_W && i < 2; i++) s = s + r[i];
        return s;
    endfunction

    function automatic int stage_lvls(input int k);
        return LVL * (k - 1) / NMID - LVL * (k - 2) / NMID;
    endfunction

    logic [STAGES:1]   v_q, v_d, adv, ld;
    logic [STAGES+1:1] rdy;
    logic [TAG_W-1:0]  tag_q [1:STAGES];
    logic [OP_W-1:0]   ea, eb;
    rows_t             fin_rows;
    logic [P_W-1:0]    p_q, p_d;

    if (HIDDEN != 0) begin : g_hidden
        assign ea = {1'b1, a};
        assign eb = {1'b1, b};
    end else begin : g_plain
        assign ea = a;
        assign eb = b;
    end

    // rdy[k]: stage k can take an entry this cycle; index STAGES+1 stands for the consumer.
    always_comb begin
        rdy = '0;
        adv = '0;
        rdy[STAGES+1] = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            adv[k] = v_q[k] && rdy[k+1];
            rdy[k] = !v_q[k] || adv[k];
        end
    end

    assign in_ready = !rst && !flush && rdy[1];

    always_comb begin
        ld    = '0;
        ld[1] = in_valid && in_ready;
        for (int k = 2; k <= STAGES; k++) ld[k] = adv[k-1];
        v_d = flush ? '0 : (ld | (v_q & ~adv));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 1; k <= STAGES; k++) tag_q[k] <= '0;
        end else begin
            v_q <= v_d;
            if (ld[1]) tag_q[1] <= tag_in;
            for (int k = 2; k <= STAGES; k++) begin
                if (ld[k]) tag_q[k] <= tag_q[k-1];
            end
        end
    end

    if (STAGES >= 2) begin : g_ops
        logic [OP_W-1:0] opa_q, opb_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                opa_q <= '0;
                opb_q <= '0;
            end else if (ld[1]) begin
                opa_q <= ea;
                opb_q <= eb;
            end
        end

        if (STAGES == 2) begin : g_fold
            assign fin_rows = pp_gen(opa_q, opb_q);
        end else begin : g_csa
            rows_t row_q [2:STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 2; k < STAGES; k++) row_q[k] <= '0;
                end else begin
                    if (ld[2]) row_q[2] <= csa_reduce(pp_gen(opa_q, opb_q), stage_lvls(2));
                    for (int k = 3; k < STAGES; k++) begin
                        if (ld[k]) row_q[k] <= csa_reduce(row_q[k-1], stage_lvls(k));
                    end
                end
            end

            assign fin_rows = row_q[STAGES-1];
        end
    end else begin : g_single
        assign fin_rows = pp_gen(ea, eb);
    end

    assign p_d = cpa(csa_reduce(fin_rows, FIN_LVL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= '0;
        else if (ld[STAGES]) p_q <= p_d;
    end

    assign out_valid = v_q[STAGES];
    assign p         = p_q;
    assign norm      = p_q[P_W-1];
    assign tag_out   = tag_q[STAGES];
    assign busy      = |v_q;
endmodule
